// File: rtl/res_drain.sv
// res_drain: serialises accumulator rows into result-buffer writes with ReLU, shift and saturation
module res_drain #(
  parameter int BIT_DEPTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_COLS   = 4,
  parameter int SHIFT_W    = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH-1:0]         num_rows,
  input  logic [SHIFT_W-1:0]            shift_amt,
  input  logic                          relu_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_COLS*ACC_WIDTH-1:0] in_data,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [BIT_DEPTH-1:0]          data_out,
  output logic                          busy,
  output logic                          done
);
  localparam int CW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
  localparam logic [1:0] IDLE = 2'd0, WAIT_ROW = 2'd1, SER = 2'd2, DONE = 2'd3;
  localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'(2 ** (BIT_DEPTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] addr, rows_left;
  logic [SHIFT_W-1:0] shift;
  logic relu;
  logic [NUM_COLS*ACC_WIDTH-1:0] row;
  logic [CW-1:0] col;
  logic signed [ACC_WIDTH-1:0] x, r, y;
  logic [BIT_DEPTH-1:0] sat;
  logic last_col;
  assign in_ready = state == WAIT_ROW;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign last_col = col == CW'(NUM_COLS - 1);
  always_comb begin
    x   = row[col*ACC_WIDTH +: ACC_WIDTH];
    r   = (relu && x < 0) ? '0 : x;
    y   = r >>> shift;
    sat = y > MAXV ? BIT_DEPTH'(MAXV) : y < MINV ? BIT_DEPTH'(MINV) : y[BIT_DEPTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      rows_left <= '0;
      shift     <= '0;
      relu      <= 1'b0;
      row       <= '0;
      col       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      data_out  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state == IDLE && start) begin
        addr      <= base_addr;
        rows_left <= num_rows;
        shift     <= shift_amt;
        relu      <= relu_en;
        state     <= num_rows == '0 ? DONE : WAIT_ROW;
      end
      if (state == WAIT_ROW && in_valid) begin
        row   <= in_data;
        col   <= '0;
        state <= SER;
      end
      if (state == SER) begin
        wr_en    <= 1'b1;
        wr_addr  <= addr;
        data_out <= sat;
        addr     <= addr + 1'b1;
        col      <= col + 1'b1;
        if (last_col) begin
          rows_left <= rows_left - 1'b1;
          state     <= rows_left == ADDR_WIDTH'(1) ? DONE : WAIT_ROW;
        end
      end
      if (state == DONE) state <= IDLE;
    end
endmodule

// File: tb/tb_res_drain.sv
// tb_res_drain: directed self-checking bench for res_drain
module tb_res_drain;
  logic clk = 0, rst_n = 0, start = 0, relu_en = 0, in_valid = 0;
  logic [9:0] base_addr = 0, num_rows = 0;
  logic [4:0] shift_amt = 0;
  logic [127:0] in_data = 0;
  logic in_ready, wr_en, busy, done;
  logic [9:0] wr_addr;
  logic [7:0] data_out;
  int checks = 0, failures = 0;
  int cyc = 0, ndone = 0, nready = 0, ks, nw;
  int wa[$], wd[$], wdone[$], wc[$];
  res_drain dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .shift_amt(shift_amt), .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .data_out(data_out),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(data_out));
      wdone.push_back(int'(done));
      wc.push_back(cyc);
    end
    if (done) ndone <= ndone + 1;
    if (in_ready) nready <= nready + 1;
  end
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] mkrow(int a, int b, int c, int d);
    return {d, c, b, a};
  endfunction
  task automatic clr();
    wa.delete(); wd.delete(); wdone.delete(); wc.delete();
  endtask
  task automatic start_job(int b, int n, int s, bit r);
    @(posedge clk); #1;
    base_addr = 10'(b); num_rows = 10'(n); shift_amt = 5'(s); relu_en = r; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic send_row(logic [127:0] d);
    bit ok = 0;
    in_valid = 1; in_data = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 0; in_data = '1;
        ok = 1;
      end
    end
    in_valid = 0;
    chk("row_accept", int'(ok), 1);
  endtask
  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      if (done) ok = 1;
    end
    chk("done_seen", int'(ok), 1);
  endtask
  task automatic chk_writes(string tag, int base, int n, int exp[]);
    chk({tag, "_count"}, wa.size(), n);
    if (wa.size() == n)
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), wa[i], (base + i) % 1024);
        chk($sformatf("%s_data%0d", tag, i), wd[i], exp[i]);
        chk($sformatf("%s_done%0d", tag, i), wdone[i], i == n - 1 ? 1 : 0);
      end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_data_out", int'(data_out), 0);
    rst_n = 1;
    // basic row: rounding toward -inf and saturation at both ends
    clr();
    start_job(12'h010, 1, 4, 0);
    send_row(mkrow(1000, 5000, -5000, -17));
    wait_done();
    chk("t1_wr_with_done", int'(wr_en), 1);
    chk_writes("t1", 12'h010, 4, '{8'h3E, 8'h7F, 8'h80, 8'hFE});
    clr();
    start_job(12'h010, 1, 4, 1);
    send_row(mkrow(1000, 5000, -5000, -17));
    wait_done();
    chk_writes("t2", 12'h010, 4, '{8'h3E, 8'h7F, 8'h00, 8'h00});
    // two rows across the address wrap; second row offered while serialising
    clr();
    start_job(12'h3FE, 2, 0, 0);
    send_row(mkrow(1, 2, 3, 4));
    send_row(mkrow(5, 6, 7, 8));
    wait_done();
    chk_writes("t3", 12'h3FE, 8, '{1, 2, 3, 4, 5, 6, 7, 8});
    if (wc.size() == 8) begin
      chk("t3_row1_consec", wc[3] - wc[0], 3);
      chk("t3_bubble", wc[4] - wc[3], 2);
      chk("t3_row2_consec", wc[7] - wc[4], 3);
    end
    // empty job
    clr();
    @(posedge clk);
    ks = nready;
    start_job(0, 0, 0, 0);
    @(negedge clk);
    chk("t4_done", int'(done), 1);
    chk("t4_busy", int'(busy), 1);
    @(negedge clk);
    chk("t4_done_gone", int'(done), 0);
    chk("t4_busy_gone", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t4_no_writes", wa.size(), 0);
    chk("t4_no_ready", nready - ks, 0);
    // asynchronous abort during the second element
    clr();
    start_job(12'h100, 2, 0, 0);
    send_row(mkrow(1, 2, 3, 4));
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("t5_wr_before", int'(wr_en), 1);
    rst_n = 0;
    #1;
    chk("t5_wr_en_abort", int'(wr_en), 0);
    chk("t5_busy_abort", int'(busy), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    nw = wa.size();
    in_valid = 1; in_data = mkrow(9, 9, 9, 9);
    repeat (8) @(negedge clk);
    chk("t5_no_more_writes", wa.size(), nw);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_ready", int'(in_ready), 0);
    in_valid = 0;
    // start with in_valid together, then start again while busy
    clr();
    @(posedge clk); #1;
    base_addr = 10'h020; num_rows = 1; shift_amt = 2; relu_en = 0; start = 1;
    in_valid = 1; in_data = mkrow(40, 80, -40, 400);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    ks = cyc;
    chk("t6_wait_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0; in_data = mkrow(-1, -1, -1, -1);
    base_addr = 10'h200; num_rows = 5; shift_amt = 0; relu_en = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done();
    chk_writes("t6", 12'h020, 4, '{8'h0A, 8'h14, 8'hF6, 8'h64});
    if (wc.size() > 0) chk("t6_first_wr_cycle", wc[0], ks + 2);
    repeat (3) @(negedge clk);
    chk("t6_no_restart", int'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
